// File: rtl/mem_req_pkg.sv
// Shared types for the memory request queue: FSM states, the buffered request
// record and the address/data widths of the memory-system interface.
package mem_req_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_req_t;

  localparam int REQ_W = $bits(mem_req_t);

  // Halfword accesses must be even-aligned; odd addresses never reach memory.
  function automatic logic is_misaligned(input mem_req_t r);
    return r.addr[0];
  endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// Request FIFO: registered write, combinational head, occupancy counter with
// one extra bit so that full and empty are distinguishable.
module mem_req_fifo
  import mem_req_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  mem_req_t               push_req,
  input  logic                   pop,
  output mem_req_t               head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  mem_req_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  // Full blocks a push even when a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr] <= push_req;
  end

endmodule

// File: rtl/mem_req_queue.sv
// Memory request front-end: queues load/store requests, issues them one at a
// time to the memory system, and returns responses with a valid/ready handshake.
module mem_req_queue
  import mem_req_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int HITW  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_wr,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_wr,
  output logic                   rsp_hit,
  output logic                   rsp_err,
  output logic                   mem_rd,
  output logic                   mem_wr,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_data_in,
  input  logic [DATA_W-1:0]      mem_data_out,
  input  logic                   mem_done,
  input  logic                   mem_cache_hit,
  input  logic                   mem_err,
  output logic [$clog2(DEPTH):0] count,
  output logic [HITW-1:0]        hit_cnt
);

  function automatic logic [HITW-1:0] sat_inc(input logic [HITW-1:0] v);
    return (&v) ? v : v + HITW'(1);
  endfunction

  state_e             state;
  state_e             state_nxt;
  mem_req_t           push_req;
  mem_req_t           head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               load_rsp;
  logic [DATA_W-1:0]  rsp_data_nxt;
  logic               rsp_wr_nxt;
  logic               rsp_hit_nxt;
  logic               rsp_err_nxt;
  logic               hit_inc;
  logic               issuing;

  assign push_req = '{wr: req_wr, addr: req_addr, data: req_data};

  mem_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (req_valid),
    .push_req (push_req),
    .pop      (pop),
    .head     (head),
    .count    (count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign req_ready = !fifo_full;
  assign rsp_valid = (state == RESP);

  // Strobes decode from the state register so they drop the cycle after Done.
  assign issuing     = (state == ISSUE);
  assign mem_rd      = issuing && !head.wr;
  assign mem_wr      = issuing && head.wr;
  assign mem_addr    = issuing ? head.addr : '0;
  assign mem_data_in = issuing ? head.data : '0;
  assign hit_inc     = issuing && mem_done && mem_cache_hit;

  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    load_rsp     = 1'b0;
    rsp_data_nxt = '0;
    rsp_wr_nxt   = head.wr;
    rsp_hit_nxt  = 1'b0;
    rsp_err_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          if (is_misaligned(head)) begin
            load_rsp    = 1'b1;
            rsp_err_nxt = 1'b1;
            pop         = 1'b1;
            state_nxt   = RESP;
          end else begin
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (mem_done || mem_err) begin
          load_rsp     = 1'b1;
          rsp_data_nxt = head.wr ? '0 : mem_data_out;
          rsp_hit_nxt  = mem_cache_hit && mem_done;
          rsp_err_nxt  = mem_err;
          pop          = 1'b1;
          state_nxt    = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rsp_data <= '0;
      rsp_wr   <= 1'b0;
      rsp_hit  <= 1'b0;
      rsp_err  <= 1'b0;
      hit_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (load_rsp) begin
        rsp_data <= rsp_data_nxt;
        rsp_wr   <= rsp_wr_nxt;
        rsp_hit  <= rsp_hit_nxt;
        rsp_err  <= rsp_err_nxt;
      end
      if (hit_inc) hit_cnt <= sat_inc(hit_cnt);
    end
  end

endmodule

// File: tb/tb_mem_req_queue.sv
// Scoreboard bench for mem_req_queue: a behavioural memory responder, an
// in-order reference model and a response monitor driving rsp_ready.
module tb_mem_req_queue;

  localparam int DEPTH = 4;
  localparam int HITW  = 4;
  localparam int HMAX  = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_wr, rsp_hit, rsp_err;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_addr, mem_data_in;
  logic [15:0] mem_data_out = '0;
  logic        mem_done = 1'b0;
  logic        mem_cache_hit = 1'b0;
  logic        mem_err = 1'b0;
  logic [2:0]  count;
  logic [HITW-1:0] hit_cnt;

  always #5 clk = ~clk;

  mem_req_queue #(.DEPTH(DEPTH), .HITW(HITW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_wr(rsp_wr), .rsp_hit(rsp_hit), .rsp_err(rsp_err),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_done(mem_done), .mem_cache_hit(mem_cache_hit), .mem_err(mem_err),
    .count(count), .hit_cnt(hit_cnt)
  );

  typedef struct { bit wr; bit [15:0] addr; bit [15:0] data; } req_s;
  typedef struct { bit [15:0] data; bit wr; bit hit; bit err; } rsp_s;
  // done=0 means the memory answers with an err pulse instead of Done
  typedef struct { int lat; bit done; bit hit; } beh_s;

  rsp_s        exp_q[$];
  req_s        iss_q[$];
  beh_s        beh_q[$];
  logic [15:0] ref_mem[256];
  logic [15:0] dev_mem[256];
  int          total = 0;
  int          bad = 0;
  int          exp_hits = 0;
  int          hold_req = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask

  // Reference model: requests complete in order, so the expected response
  // follows from memory contents as of all earlier requests.
  task automatic model(input bit wr, input bit [15:0] addr, input bit [15:0] data, input beh_s b);
    rsp_s e;
    e.wr = wr; e.data = '0; e.hit = 1'b0; e.err = 1'b0;
    if (addr[0]) begin
      e.err = 1'b1;
    end else begin
      req_s r;
      r.wr = wr; r.addr = addr; r.data = data;
      iss_q.push_back(r);
      beh_q.push_back(b);
      e.hit = b.done && b.hit;
      e.err = !b.done;
      if (wr) begin
        if (b.done) ref_mem[addr[7:0]] = data;
      end else begin
        e.data = ref_mem[addr[7:0]];
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic send(input bit wr, input bit [15:0] addr, input bit [15:0] data,
                      input beh_s b, output bit acc);
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_data = data;
    acc = req_ready;
    @(posedge clk);
    if (acc) model(wr, addr, data, b);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || count != 0 || rsp_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_timeout"}, 32'(n < 400), 32'd1);
  endtask

  // Memory responder
  initial begin
    req_s cur_r;
    beh_s cur_b;
    bit   busy = 1'b0;
    bit   after_done = 1'b0;
    int   left = 0;
    cur_r = '{0, 0, 0};
    cur_b = '{0, 0, 0};
    forever begin
      @(negedge clk);
      mem_done = 1'b0; mem_err = 1'b0; mem_cache_hit = 1'b0;
      mem_data_out = 16'($urandom);
      if (!rst) begin
        busy = 1'b0; after_done = 1'b0;
      end else if (after_done) begin
        after_done = 1'b0;
        check("rdwr_after_done", 32'(mem_rd | mem_wr), 32'd0);
        check("rsp_valid_after_done", 32'(rsp_valid), 32'd1);
      end else if (mem_rd || mem_wr) begin
        if (!busy) begin
          if (iss_q.size() == 0 || beh_q.size() == 0) begin
            check("unexpected_mem_access", 32'd1, 32'd0);
          end else begin
            cur_r = iss_q.pop_front();
            cur_b = beh_q.pop_front();
            busy = 1'b1;
            left = cur_b.lat;
            check("mem_issue", {13'd0, mem_rd, mem_wr, mem_addr},
                  {13'd0, !cur_r.wr, cur_r.wr, cur_r.addr});
            if (cur_r.wr) check("mem_data_in", 32'(mem_data_in), 32'(cur_r.data));
          end
        end else begin
          check("mem_stable", {13'd0, mem_rd, mem_wr, mem_addr},
                {13'd0, !cur_r.wr, cur_r.wr, cur_r.addr});
        end
        if (busy) begin
          if (left == 0) begin
            if (!cur_r.wr) mem_data_out = dev_mem[cur_r.addr[7:0]];
            if (cur_b.done) begin
              mem_done = 1'b1;
              mem_cache_hit = cur_b.hit;
              if (cur_r.wr) dev_mem[cur_r.addr[7:0]] = cur_r.data;
            end else begin
              mem_err = 1'b1;
              mem_cache_hit = 1'($urandom_range(0, 1));
            end
            busy = 1'b0;
            after_done = 1'b1;
          end else begin
            left--;
          end
        end
      end else if (busy) begin
        check("mem_dropped", 32'd1, 32'd0);
        busy = 1'b0;
      end
    end
  end

  // Response monitor and rsp_ready driver
  initial begin
    rsp_s cur;
    bit   held = 1'b0;
    int   force_low = 0;
    cur = '{0, 0, 0, 0};
    forever begin
      @(negedge clk);
      if (!rst) begin
        held = 1'b0; force_low = 0; rsp_ready = 1'b0;
      end else if (rsp_valid) begin
        check("rdwr_while_rsp", 32'(mem_rd | mem_wr), 32'd0);
        if (!held) begin
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", 32'd1, 32'd0);
          end else begin
            cur = exp_q.pop_front();
            held = 1'b1;
            if (cur.hit && exp_hits < HMAX) exp_hits++;
            check("rsp_data", 32'(rsp_data), 32'(cur.data));
            check("rsp_flags", {29'd0, rsp_wr, rsp_hit, rsp_err},
                  {29'd0, cur.wr, cur.hit, cur.err});
            check("hit_cnt", 32'(hit_cnt), 32'(exp_hits));
            force_low = hold_req;
            hold_req = 0;
          end
        end else begin
          check("rsp_stable", {13'd0, rsp_data, rsp_wr, rsp_hit, rsp_err},
                {13'd0, cur.data, cur.wr, cur.hit, cur.err});
        end
        if (force_low > 0) begin
          rsp_ready = 1'b0;
          force_low--;
        end else begin
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
        if (rsp_ready) held = 1'b0;
      end else begin
        rsp_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Stimulus
  initial begin
    bit acc;
    int seen;
    foreach (ref_mem[i]) begin ref_mem[i] = '0; dev_mem[i] = '0; end

    repeat (3) @(negedge clk);
    check("reset_outputs", {19'd0, req_ready, rsp_valid, mem_rd, mem_wr, rsp_wr, rsp_hit, rsp_err, count},
          {19'd0, 1'b1, 9'd0});
    check("reset_rsp_data", 32'(rsp_data), 32'd0);
    check("reset_hit_cnt", 32'(hit_cnt), 32'd0);
    @(posedge clk); #2 rst = 1'b1;

    // Single load with a 5-cycle memory access
    ref_mem[8'h10] = 16'hBEEF; dev_mem[8'h10] = 16'hBEEF;
    send(1'b0, 16'h0010, 16'h0, '{4, 1'b1, 1'b0}, acc);
    @(negedge clk); check("load_idle_cycle_rd", 32'(mem_rd), 32'd0);
    @(negedge clk); check("load_issue_rd", 32'(mem_rd), 32'd1);
    wait_idle("single_load");

    // Four stores fill the queue while memory stalls; the fifth is refused
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 16'(16'h0020 + 2 * i), 16'(16'hA000 + i), '{12, 1'b1, 1'b0}, acc);
      check("store_accept", 32'(acc), 32'd1);
    end
    @(negedge clk);
    check("full_count", 32'(count), 32'd4);
    check("full_ready", 32'(req_ready), 32'd0);
    send(1'b1, 16'h0028, 16'h5555, '{0, 1'b1, 1'b0}, acc);
    check("fifth_refused", 32'(acc), 32'd0);
    @(negedge clk); check("full_count_held", 32'(count), 32'd4);
    wait_idle("stores");
    check("drained_count", 32'(count), 32'd0);

    // Misaligned load: answered locally, never reaches memory
    send(1'b0, 16'h0003, 16'h0, '{0, 1'b1, 1'b0}, acc);
    @(negedge clk); check("misaligned_wait", 32'(rsp_valid), 32'd0);
    @(negedge clk); check("misaligned_rsp", {30'd0, rsp_valid, rsp_err}, {30'd0, 2'b11});
    wait_idle("misaligned");

    // Back-pressure on the response path
    hold_req = 3;
    send(1'b0, 16'h0020, 16'h0, '{1, 1'b1, 1'b1}, acc);
    send(1'b0, 16'h0022, 16'h0, '{0, 1'b1, 1'b0}, acc);
    wait_idle("backpressure");

    // Memory error without Done, then the FSM moves on
    send(1'b0, 16'h0024, 16'h0, '{2, 1'b0, 1'b0}, acc);
    send(1'b1, 16'h0030, 16'h1234, '{1, 1'b0, 1'b0}, acc);
    send(1'b0, 16'h0030, 16'h0, '{0, 1'b1, 1'b1}, acc);
    wait_idle("mem_err");

    // Asynchronous reset in the middle of an access
    send(1'b0, 16'h0040, 16'h0, '{40, 1'b1, 1'b1}, acc);
    send(1'b1, 16'h0042, 16'h7777, '{0, 1'b1, 1'b0}, acc);
    send(1'b0, 16'h0044, 16'h0, '{0, 1'b1, 1'b0}, acc);
    seen = 0;
    while (!mem_rd && seen < 10) begin @(negedge clk); seen++; end
    check("reset_test_issue", 32'(mem_rd), 32'd1);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    check("rst_mid_rd", 32'(mem_rd), 32'd0);
    check("rst_mid_state", {27'd0, req_ready, rsp_valid, count}, {27'd0, 1'b1, 1'b0, 3'd0});
    check("rst_mid_hit_cnt", 32'(hit_cnt), 32'd0);
    exp_q.delete(); iss_q.delete(); beh_q.delete();
    ref_mem = dev_mem;
    exp_hits = 0; hold_req = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid || mem_rd || mem_wr || count != 0) seen++;
    end
    check("quiet_after_reset", 32'(seen), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      bit [15:0] a;
      bit        w;
      beh_s      b;
      int        k, tries;
      w = 1'($urandom_range(0, 1));
      a = 16'($urandom);
      if ($urandom_range(0, 9) != 0) a[0] = 1'b0;
      k = $urandom_range(0, 9);
      b.lat = $urandom_range(0, 4);
      b.done = (k < 8);
      b.hit = (k < 5);
      tries = 0;
      acc = 1'b0;
      while (!acc && tries < 200) begin
        send(w, a, 16'($urandom), b, acc);
        tries++;
      end
      check("random_accept", 32'(acc), 32'd1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle("random");
    check("final_count", 32'(count), 32'd0);
    check("hit_cnt_saturated", 32'(hit_cnt), 32'(HMAX));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
